l1d_mmu_bridge: RTL and testbench

//  Sits directly downstream of the L1 data cache. Serves its line fill/write-back requests (256-bit lines)
//  and single-word MMIO requests by serialising them into 32-bit beats on the word memory bus.

---
 rtl/l1d_mmu_bridge_if.sv | 33 +++
 rtl/l1d_mmu_bridge.sv | 167 ++++++++++++++++
 tb/tb_l1d_mmu_bridge.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/l1d_mmu_bridge_if.sv
// Cache-side request/response and word-bus signals of the L1D-to-memory bridge.
// The master modport is the bridge's view; slave is the view of the cache/memory environment.
interface l1d_mmu_bridge_if;
  logic         l1_mmu_req_read;
  logic         l1_mmu_req_write;
  logic [31:0]  l1_mmu_req_addr;
  logic [255:0] l1_mmu_write_data;
  logic         mmu_l1_done;
  logic [255:0] mmu_l1_read_data;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         mmu_busy;

  modport master (
    input  l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
    output mmu_l1_done, mmu_l1_read_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output mmu_busy
  );

  modport slave (
    output l1_mmu_req_read, l1_mmu_req_write, l1_mmu_req_addr, l1_mmu_write_data,
    input  mmu_l1_done, mmu_l1_read_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  mmu_busy
  );
endinterface

// File: rtl/l1d_mmu_bridge.sv
// Serialises L1D 256-bit line fills/write-backs and MMIO words into 32-bit beats on the word bus.
// All outputs come straight from flops loaded with the values implied by the next state.
module l1d_mmu_bridge #(
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
  input  logic              sys_clk,
  input  logic              rst,
  l1d_mmu_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WLINE = 3'd1,
    ST_RLINE = 3'd2,
    ST_MMIO  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_mmio_addr(input logic [31:0] a);
    return (a & MMIO_MASK) == MMIO_BASE;
  endfunction

  state_t       state_r,      state_nxt_s;
  logic [2:0]   beat_r,       beat_nxt_s;
  logic [31:0]  addr_r,       addr_nxt_s;
  logic [255:0] wdata_r,      wdata_nxt_s;
  logic         op_write_r,   op_write_nxt_s;
  logic [255:0] rdata_r,      rdata_nxt_s;
  logic         mem_req_r,    mem_req_nxt_s;
  logic         mem_we_r,     mem_we_nxt_s;
  logic [31:0]  mem_addr_r,   mem_addr_nxt_s;
  logic [31:0]  mem_wdata_r,  mem_wdata_nxt_s;
  logic         done_r,       done_nxt_s;
  logic         busy_r,       busy_nxt_s;
  logic         beat_ack_s;

  // An ack only completes a beat while a request is actually on the bus.
  assign beat_ack_s = mem_req_r & bus.mem_ack;

  // Next-state, request latching, read-data capture and next output values.
  always_comb begin
    state_nxt_s    = state_r;
    beat_nxt_s     = beat_r;
    addr_nxt_s     = addr_r;
    wdata_nxt_s    = wdata_r;
    op_write_nxt_s = op_write_r;
    rdata_nxt_s    = rdata_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.l1_mmu_req_write || bus.l1_mmu_req_read) begin
          addr_nxt_s     = bus.l1_mmu_req_addr;
          wdata_nxt_s    = bus.l1_mmu_write_data;
          op_write_nxt_s = bus.l1_mmu_req_write;
          beat_nxt_s     = 3'd0;
          if (is_mmio_addr(bus.l1_mmu_req_addr)) begin
            state_nxt_s = ST_MMIO;
          end else if (bus.l1_mmu_req_write) begin
            state_nxt_s = ST_WLINE;
          end else begin
            state_nxt_s = ST_RLINE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WLINE, ST_RLINE: begin
        if (beat_ack_s) begin
          if (state_r == ST_RLINE) begin
            rdata_nxt_s[{beat_r, 5'd0} +: 32] = bus.mem_rdata;
          end else begin
            rdata_nxt_s = rdata_r;
          end
          if (beat_r == 3'd7) begin
            state_nxt_s = ST_DONE;
          end else begin
            beat_nxt_s = beat_r + 3'd1;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_MMIO: begin
        if (beat_ack_s) begin
          if (!op_write_r) begin
            rdata_nxt_s = {224'd0, bus.mem_rdata};
          end else begin
            rdata_nxt_s = rdata_r;
          end
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_MMIO;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    mem_req_nxt_s   = 1'b0;
    mem_we_nxt_s    = 1'b0;
    mem_addr_nxt_s  = 32'd0;
    mem_wdata_nxt_s = 32'd0;
    case (state_nxt_s)
      ST_WLINE: begin
        mem_req_nxt_s   = 1'b1;
        mem_we_nxt_s    = 1'b1;
        mem_addr_nxt_s  = {addr_nxt_s[31:5], beat_nxt_s, 2'b00};
        mem_wdata_nxt_s = wdata_nxt_s[{beat_nxt_s, 5'd0} +: 32];
      end
      ST_RLINE: begin
        mem_req_nxt_s   = 1'b1;
        mem_addr_nxt_s  = {addr_nxt_s[31:5], beat_nxt_s, 2'b00};
      end
      ST_MMIO: begin
        mem_req_nxt_s   = 1'b1;
        mem_we_nxt_s    = op_write_nxt_s;
        mem_addr_nxt_s  = addr_nxt_s;
        mem_wdata_nxt_s = op_write_nxt_s ? wdata_nxt_s[31:0] : 32'd0;
      end
      default: mem_req_nxt_s = 1'b0;
    endcase

    done_nxt_s = (state_nxt_s == ST_DONE);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and registered outputs; reset drops any beat in flight without a done pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      beat_r      <= 3'd0;
      addr_r      <= 32'd0;
      wdata_r     <= 256'd0;
      op_write_r  <= 1'b0;
      rdata_r     <= 256'd0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      beat_r      <= beat_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      op_write_r  <= op_write_nxt_s;
      rdata_r     <= rdata_nxt_s;
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      done_r      <= done_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign bus.mem_req          = mem_req_r;
  assign bus.mem_we           = mem_we_r;
  assign bus.mem_addr         = mem_addr_r;
  assign bus.mem_wdata        = mem_wdata_r;
  assign bus.mmu_l1_done      = done_r;
  assign bus.mmu_l1_read_data = rdata_r;
  assign bus.mmu_busy         = busy_r;

endmodule

// File: tb/tb_l1d_mmu_bridge.sv
// Randomised bench for l1d_mmu_bridge: a transaction-level model predicts the beat list,
// the done latency and the returned line, while the bench plays the word-bus slave.
module tb_l1d_mmu_bridge;

  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_MASK = 32'hFFFF_0000;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;
  logic [255:0] model_rdata = 256'd0;

  l1d_mmu_bridge_if bus ();

  l1d_mmu_bridge #(.MMIO_BASE(MMIO_BASE), .MMIO_MASK(MMIO_MASK)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_wait(input int fixed_wait);
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  // Runs one request from accept to done (or to a reset abort at beat abort_beat).
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [255:0] wd, input int fixed_wait,
                         input int abort_beat, input logic keep_read);
    logic         is_mmio, is_wr, finished, aborted;
    int           nbeats, idx, wcnt, cyc, exp_done_cyc;
    logic [2:0]   k;
    logic [31:0]  exp_a, exp_d, rv;
    logic [255:0] new_rdata;

    is_wr     = wr;
    is_mmio   = ((addr & MMIO_MASK) == MMIO_BASE);
    nbeats    = is_mmio ? 1 : 8;
    new_rdata = model_rdata;

    bus.l1_mmu_req_read   = rd;
    bus.l1_mmu_req_write  = wr;
    bus.l1_mmu_req_addr   = addr;
    bus.l1_mmu_write_data = wd;
    bus.mem_ack           = 1'b0;
    @(posedge sys_clk);

    idx = 0; cyc = 0; finished = 1'b0; aborted = 1'b0;
    wcnt = pick_wait(fixed_wait);
    exp_done_cyc = wcnt + 1;
    while (!finished && cyc < 300) begin
      @(negedge sys_clk);
      cyc++;
      bus.l1_mmu_req_read   = 1'($urandom_range(0, 1));
      bus.l1_mmu_req_write  = 1'($urandom_range(0, 1));
      bus.l1_mmu_req_addr   = $urandom;
      bus.l1_mmu_write_data = {8{$urandom}};
      bus.mem_ack           = 1'b0;
      bus.mem_rdata         = $urandom;
      if (bus.mmu_l1_done) begin
        check_eq("done_cycle", 256'(cyc), 256'(exp_done_cyc));
        check_eq("done_beats", 256'(idx), 256'(nbeats));
        check_eq("done_rdata", bus.mmu_l1_read_data, new_rdata);
        check_eq("done_req", 256'(bus.mem_req), 256'd0);
        model_rdata = new_rdata;
        bus.l1_mmu_req_read  = keep_read;
        bus.l1_mmu_req_write = 1'b0;
        bus.mem_ack          = 1'($urandom_range(0, 1));
        finished = 1'b1;
      end else begin
        check_eq("busy", 256'(bus.mmu_busy), 256'd1);
        check_eq("req", 256'(bus.mem_req), 256'(idx < nbeats));
        if (bus.mem_req && idx < nbeats) begin
          k     = idx[2:0];
          exp_a = is_mmio ? addr : {addr[31:5], k, 2'b00};
          exp_d = is_mmio ? wd[31:0] : wd[32*idx +: 32];
          check_eq("beat_we", 256'(bus.mem_we), 256'(is_wr));
          check_eq("beat_addr", 256'(bus.mem_addr), 256'(exp_a));
          if (is_wr) check_eq("beat_wdata", 256'(bus.mem_wdata), 256'(exp_d));
          if (abort_beat == idx) begin
            aborted  = 1'b1;
            finished = 1'b1;
          end else if (wcnt == 0) begin
            rv = $urandom;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rv;
            if (!is_wr) begin
              if (is_mmio) new_rdata = {224'd0, rv};
              else         new_rdata[32*idx +: 32] = rv;
            end
            idx++;
            if (idx < nbeats) begin
              wcnt = pick_wait(fixed_wait);
              exp_done_cyc += wcnt + 1;
            end else begin
              exp_done_cyc += 1;
            end
          end else begin
            wcnt--;
          end
        end
      end
    end

    if (!finished) begin
      check_eq("timeout", 256'd0, 256'd1);
    end else if (aborted) begin
      bus.l1_mmu_req_read  = 1'b0;
      bus.l1_mmu_req_write = 1'b0;
      rst = 1'b1;
      @(negedge sys_clk);
      check_eq("abort_req", 256'(bus.mem_req), 256'd0);
      check_eq("abort_busy", 256'(bus.mmu_busy), 256'd0);
      check_eq("abort_done", 256'(bus.mmu_l1_done), 256'd0);
      check_eq("abort_rdata", bus.mmu_l1_read_data, 256'd0);
      model_rdata = 256'd0;
      rst = 1'b0;
      @(negedge sys_clk);
      check_eq("abort_nodone", 256'(bus.mmu_l1_done), 256'd0);
    end else begin
      @(negedge sys_clk);
      check_eq("post_done", 256'(bus.mmu_l1_done), 256'd0);
      check_eq("post_busy", 256'(bus.mmu_busy), 256'd0);
      check_eq("post_req", 256'(bus.mem_req), 256'd0);
      bus.mem_ack = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    logic [255:0] wd;
    logic [31:0]  a;
    logic         mm;
    int           op, ab;

    bus.l1_mmu_req_read   = 1'b0;
    bus.l1_mmu_req_write  = 1'b0;
    bus.l1_mmu_req_addr   = 32'd0;
    bus.l1_mmu_write_data = 256'd0;
    bus.mem_ack           = 1'b0;
    bus.mem_rdata         = 32'd0;
    repeat (3) @(negedge sys_clk);
    check_eq("rst_req", 256'(bus.mem_req), 256'd0);
    check_eq("rst_we", 256'(bus.mem_we), 256'd0);
    check_eq("rst_addr", 256'(bus.mem_addr), 256'd0);
    check_eq("rst_wdata", 256'(bus.mem_wdata), 256'd0);
    check_eq("rst_done", 256'(bus.mmu_l1_done), 256'd0);
    check_eq("rst_busy", 256'(bus.mmu_busy), 256'd0);
    check_eq("rst_rdata", bus.mmu_l1_read_data, 256'd0);
    rst = 1'b0;
    @(negedge sys_clk);

    run_txn(1'b1, 1'b0, 32'h0000_1234, {8{$urandom}}, 0, -1, 1'b0);
    for (int i = 0; i < 8; i++) wd[32*i +: 32] = 32'h1111_1111 * i;
    run_txn(1'b0, 1'b1, 32'h0000_8000, wd, 2, -1, 1'b0);
    run_txn(1'b1, 1'b1, 32'h0000_4460, {8{$urandom}}, -1, -1, 1'b1);
    run_txn(1'b1, 1'b0, 32'h0000_4460, {8{$urandom}}, -1, -1, 1'b0);
    run_txn(1'b1, 1'b0, 32'hFFFF_0004, {8{$urandom}}, 0, -1, 1'b0);
    check_eq("mmio_rd_hi", 256'(bus.mmu_l1_read_data[255:32]), 256'd0);
    wd = {8{$urandom}};
    wd[31:0] = 32'h0000_005A;
    run_txn(1'b0, 1'b1, 32'hFFFF_0010, wd, 0, -1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, {8{$urandom}}, 0, 3, 1'b0);
    run_txn(1'b1, 1'b0, 32'h0000_2000, {8{$urandom}}, -1, -1, 1'b0);

    for (int t = 0; t < 40; t++) begin
      mm = ($urandom_range(0, 3) == 0);
      a  = mm ? {16'hFFFF, 16'($urandom)} : $urandom;
      op = int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_txn(op[0], op[1], a, {8{$urandom}}, -1, ab, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
